// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: RV32I load/store initiator onto a word-organised data memory
module lsu_mem_initiator #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d, acc_state;
  logic store_q, err_q, err_d, illegal, misal;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [DM_ADDRESS-1:0] a_q;
  logic [31:0] wd_q, rdata_q, sh_rd, ld_d, mask, ins, mrg;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  // decode the incoming request, pick the next state, and build load/merge data from mem_rd
  always_comb begin
    illegal = req_store ? (req_funct3 > 3'd2) : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110);
    misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    err_d = illegal | misal;
    acc_state = err_d ? DONE : (req_store && req_funct3[1:0] == 2'b10) ? WR : RD;
    state_d = state_q == IDLE ? (req_valid ? acc_state : IDLE) :
              state_q == RD   ? (store_q ? WR : DONE) :
              state_q == WR   ? DONE : IDLE;
    sh_rd = mem_rd >> {off_q, 3'b000};
    byte_v = sh_rd[7:0];
    half_v = off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    ld_d = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_v[7]}}, byte_v} :
           f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_v[15]}}, half_v} : mem_rd;
    mask = f3_q[0] ? (32'h0000FFFF << {off_q[1], 4'b0000}) : (32'h000000FF << {off_q, 3'b000});
    ins = f3_q[0] ? ({16'b0, wd_q[15:0]} << {off_q[1], 4'b0000}) : ({24'b0, wd_q[7:0]} << {off_q, 3'b000});
    mrg = (mem_rd & ~mask) | ins;
  end
  // capture the request in IDLE, then the extended load or merged store word at the end of RD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      a_q     <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        a_q     <= req_addr[DM_ADDRESS+1:2];
        wd_q    <= req_wdata;
        rdata_q <= '0;
        err_q   <= err_d;
      end else if (state_q == RD) begin
        if (store_q) wd_q <= mrg;
        else rdata_q <= ld_d;
      end
    end
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == DONE;
  assign mem_read   = state_q == RD;
  assign mem_write  = state_q == WR;
  assign mem_a      = a_q;
  assign mem_wd     = wd_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed requests with a scoreboard checked by a response monitor
module tb_lsu_mem_initiator;
  logic clk = 1'b0, reset, req_valid, req_ready, req_store, resp_valid, resp_err, mem_read, mem_write;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_wd, mem_rd;
  logic [8:0] mem_a;
  logic [31:0] mem [0:511];
  logic chk_rst = 1'b0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, total = 0, bad = 0;
  logic [8:0] last_ra = '0, last_wa = '0;
  logic [31:0] last_wd = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat, c0, rd0, wr0, nrd, nwr;
    logic [8:0]  a;
    logic [31:0] wd;
  } exp_t;
  exp_t sb[$];
  exp_t me;

  lsu_mem_initiator dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rd = mem[mem_a];
  always @(posedge clk) if (mem_write) mem[mem_a] <= mem_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_read) begin
      rd_cnt <= rd_cnt + 1;
      last_ra <= mem_a;
    end
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      last_wa <= mem_a;
      last_wd <= mem_wd;
    end
    if (chk_rst) begin
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
      chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
      chk("rst_mem_a", {23'b0, mem_a}, 32'd0);
      chk("rst_mem_wd", mem_wd, 32'd0);
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: resp_valid=1 with empty scoreboard (cycle %0d)", cyc);
      end else begin
        me = sb.pop_front();
        chk("resp_rdata", resp_rdata, me.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, me.err});
        chk("latency", cyc - me.c0, me.lat);
        chk("ready_busy", {31'b0, req_ready}, 32'd0);
        chk("mem_read_count", rd_cnt - me.rd0, me.nrd);
        chk("mem_write_count", wr_cnt - me.wr0, me.nwr);
        if (me.nrd > 0) chk("read_addr", {23'b0, last_ra}, {23'b0, me.a});
        if (me.nwr > 0) begin
          chk("write_addr", {23'b0, last_wa}, {23'b0, me.a});
          chk("write_data", last_wd, me.wd);
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat, input int nrd, input int nwr,
                       input logic [8:0] ea, input logic [31:0] ewd);
    exp_t e;
    @(negedge clk);
    e.rdata = er; e.err = ee; e.lat = lat; e.c0 = cyc; e.rd0 = rd_cnt; e.wr0 = wr_cnt;
    e.nrd = nrd; e.nwr = nwr; e.a = ea; e.wd = ewd;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = ad; req_wdata = wd;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      $display("FAIL timeout: no response for addr %h", ad);
      $fatal(1, "response timeout");
    end
  endtask

  task automatic rst_check();
    chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    rst_check();
    reset = 1'b0;
    rst_check();
    issue(1, 3'd2, 32'h14, 32'h8899AABB, 32'h0, 0, 2, 0, 1, 9'd5, 32'h8899AABB);
    issue(0, 3'd0, 32'h15, 32'h0, 32'hFFFFFFAA, 0, 2, 1, 0, 9'd5, 32'h0);
    issue(0, 3'd4, 32'h15, 32'h0, 32'h000000AA, 0, 2, 1, 0, 9'd5, 32'h0);
    issue(0, 3'd1, 32'h16, 32'h0, 32'hFFFF8899, 0, 2, 1, 0, 9'd5, 32'h0);
    issue(0, 3'd5, 32'h16, 32'h0, 32'h00008899, 0, 2, 1, 0, 9'd5, 32'h0);
    issue(0, 3'd2, 32'h14, 32'h0, 32'h8899AABB, 0, 2, 1, 0, 9'd5, 32'h0);
    issue(1, 3'd2, 32'h20, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 9'd8, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h20, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, 9'd8, 32'h0);
    issue(1, 3'd2, 32'h20, 32'h11223344, 32'h0, 0, 2, 0, 1, 9'd8, 32'h11223344);
    issue(1, 3'd0, 32'h22, 32'h000000AB, 32'h0, 0, 3, 1, 1, 9'd8, 32'h11AB3344);
    issue(1, 3'd2, 32'h20, 32'h11223344, 32'h0, 0, 2, 0, 1, 9'd8, 32'h11223344);
    issue(1, 3'd1, 32'h20, 32'h0000CAFE, 32'h0, 0, 3, 1, 1, 9'd8, 32'h1122CAFE);
    issue(1, 3'd0, 32'h23, 32'hFFFFFF55, 32'h0, 0, 3, 1, 1, 9'd8, 32'h5522CAFE);
    issue(0, 3'd0, 32'h22, 32'h0, 32'h00000022, 0, 2, 1, 0, 9'd8, 32'h0);
    issue(0, 3'd1, 32'h22, 32'h0, 32'h00005522, 0, 2, 1, 0, 9'd8, 32'h0);
    issue(1, 3'd1, 32'h22, 32'h00009876, 32'h0, 0, 3, 1, 1, 9'd8, 32'h9876CAFE);
    issue(0, 3'd1, 32'h22, 32'h0, 32'hFFFF9876, 0, 2, 1, 0, 9'd8, 32'h0);
    issue(0, 3'd2, 32'h21, 32'h0, 32'h0, 1, 1, 0, 0, 9'd0, 32'h0);
    issue(1, 3'd1, 32'h23, 32'h1234, 32'h0, 1, 1, 0, 0, 9'd0, 32'h0);
    issue(0, 3'd3, 32'h20, 32'h0, 32'h0, 1, 1, 0, 0, 9'd0, 32'h0);
    issue(1, 3'd4, 32'h20, 32'h0, 32'h0, 1, 1, 0, 0, 9'd0, 32'h0);
    issue(0, 3'd1, 32'h15, 32'h0, 32'h0, 1, 1, 0, 0, 9'd0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h22; req_wdata = 32'h000000AB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    rst_check();
    reset = 1'b0;
    rst_check();
    issue(0, 3'd2, 32'h20, 32'h0, 32'h9876CAFE, 0, 2, 1, 0, 9'd8, 32'h0);
    issue(1, 3'd2, 32'h04, 32'h0BADF00D, 32'h0, 0, 2, 0, 1, 9'd1, 32'h0BADF00D);
    issue(0, 3'd2, 32'h10000804, 32'h0, 32'h0BADF00D, 0, 2, 1, 0, 9'd1, 32'h0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the core's execute stage and the word-organised data memory.
- Accepts one load or store request at a time. Translates RV32I byte, halfword and word accesses into whole-word memory reads and writes.
- Sub-word stores are done as read-modify-write.
- Loads are returned to the core with RV32I sign or zero extension.
- Misaligned accesses are flagged; no memory access is made for them.

Parameters:
- DM_ADDRESS, 9, word-address width of the data memory (2**DM_ADDRESS words).
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or low half is used for SB or SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned access or illegal funct3.
- mem_read  out  1  to data memory read enable.
- mem_write  out  1  to data memory write enable; memory writes on the clk rising edge.
- mem_a  out  DM_ADDRESS  word address = req_addr[DM_ADDRESS+1:2].
- mem_wd  out  32  write word.
- mem_rd  in  32  read word; combinational from the memory, valid in the same cycle as mem_read.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - resp_valid, resp_err, mem_read, mem_write = 0.
  - resp_rdata, mem_a, mem_wd and all captured request registers = 0.
- States: IDLE, RD, WR, DONE.
- Outputs per state:
  - mem_read = 1 only in RD.
  - mem_write = 1 only in WR.
  - mem_a and mem_wd are registered and stable for the whole RD/WR cycle.
- Acceptance: in IDLE, req_valid=1 captures store, funct3, addr[1:0], word address and wdata. Request inputs are ignored in every other state.
- Decode at acceptance:
  - Illegal: load funct3 011/110/111, or store funct3 other than 000/001/010.
  - Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
  - Illegal or misaligned goes directly to DONE with resp_err=1. No mem_read or mem_write is ever asserted for such a request.
- Transitions:
  - Load: IDLE -> RD -> DONE.
  - SW: IDLE -> WR -> DONE, with mem_wd = req_wdata.
  - SB/SH: IDLE -> RD -> WR -> DONE.
- RD capture: mem_rd is captured at the end of RD.
  - Load: extract the byte at offset addr[1:0] or the half at addr[1], then sign-extend (B/H) or zero-extend (BU/HU) into resp_rdata.
  - SB/SH: merge the store data into the captured word. Only the addressed byte or half is replaced; all other bits keep their read values. The merged word is placed on mem_wd for WR.
- DONE: resp_valid=1 for exactly one cycle, then back to IDLE. resp_rdata and resp_err hold until the next acceptance.
- Latency from acceptance cycle to resp_valid:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- req_ready=0 from the cycle after acceptance through DONE. A back-to-back request is accepted in the cycle after DONE.
- Address bits above DM_ADDRESS+1 are ignored, so the word address wraps modulo 2**DM_ADDRESS.
- Reset asserted mid-operation returns the block to IDLE immediately. If reset arrives during WR, before the clock edge, no write occurs.

Test Plan:
- Memory word 5 = 0x8899AABB; LB at addr 0x15 (offset 1) -> resp_valid 2 cycles after acceptance, resp_rdata=0xFFFFFFAA, resp_err=0; LBU at the same address -> 0x000000AA.
- Memory word 5 = 0x8899AABB; LH at 0x16 -> 0xFFFF8899; LHU at 0x16 -> 0x00008899; LW at 0x14 -> 0x8899AABB.
- SW 0xDEADBEEF to 0x20 -> one mem_write pulse with mem_a=8, mem_wd=0xDEADBEEF, no mem_read; a following LW at 0x20 returns 0xDEADBEEF.
- Word 8 = 0x11223344; SB of wdata 0x000000AB at 0x22 -> mem_read then mem_write, mem_wd=0x11AB3344, resp_valid 3 cycles after acceptance; SH of 0x0000CAFE at 0x20 -> mem_wd=0x1122CAFE.
- LW at 0x21, SH at 0x23, and load funct3=011 -> each gives resp_valid with resp_err=1 one cycle after acceptance, with mem_read and mem_write never asserted.
- Reset during the WR cycle of an SB -> no memory write, outputs at reset values, req_ready=1; an LW at 0x1000_0804 then uses mem_a=0x001 (upper bits ignored).
